// File: rtl/bmp_pkg.sv
// rtl/bmp_pkg.sv - shared BMP constants, FSM states and row-stride helper
package bmp_pkg;

  localparam int BMP_HDR_BYTES = 54;
  localparam int WIDTH_OFS     = 18;
  localparam int HEIGHT_OFS    = 22;

  typedef enum logic [2:0] {
    IDLE, HDR_RD, HDR_CAP, CHECK, PIX_RD, PIX_WR, DONE
  } bmpState_t;

  // BMP rows are 3 bytes per pixel rounded up to a multiple of 4
  function automatic logic [12:0] padded_stride(input logic [10:0] w);
    logic [12:0] raw;
    raw = 13'(w) * 13'd3 + 13'd3;
    return raw & ~13'd3;
  endfunction

endpackage

// File: rtl/bmp_addr_gen.sv
// rtl/bmp_addr_gen.sv - source (bottom-up, padded) and destination (top-down, dense) byte addresses
module bmp_addr_gen
  import bmp_pkg::*;
#(
  parameter int HDR_BYTES = BMP_HDR_BYTES
) (
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic [1:0]  rgb,
  input  logic [10:0] width,
  input  logic [10:0] height,
  input  logic [12:0] stride,
  output logic [31:0] srcAddr,
  output logic [31:0] dstAddr
);

  logic [31:0] srcRow;
  logic [31:0] col;

  always_comb begin
    srcRow  = 32'(height) - 32'd1 - 32'(y);
    col     = 32'd3 * 32'(x) + 32'(rgb);
    srcAddr = 32'(HDR_BYTES) + srcRow * 32'(stride) + col;
    dstAddr = 32'(y) * 32'd3 * 32'(width) + col;
  end

endmodule

// File: rtl/bmp_unpad.sv
// rtl/bmp_unpad.sv - converts a padded bottom-up BMP buffer into a dense top-down BGR raw buffer
module bmp_unpad
  import bmp_pkg::*;
#(
  parameter int MAX_WIDTH  = 640,
  parameter int MAX_HEIGHT = 480,
  parameter int HDR_BYTES  = BMP_HDR_BYTES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  output logic        err,
  output logic [31:0] readAddr,
  input  logic [7:0]  readdata,
  output logic [31:0] writeAddr,
  output logic [7:0]  wrdata,
  output logic        wren,
  output logic [10:0] width,
  output logic [10:0] height
);

  localparam logic [2:0] HDR_LAST = 3'(HEIGHT_OFS + 3 - WIDTH_OFS);

  bmpState_t   state, nextState;
  logic [2:0]  idx;
  logic [63:0] hdr;
  logic [31:0] hdrW, hdrH;
  logic        hdrBad;
  logic [10:0] x, y, nx, ny;
  logic [1:0]  rgb, nRgb;
  logic [12:0] stride;
  logic        errReg;
  logic        lastByte;
  logic [10:0] geoW, geoH;
  logic [12:0] geoS;
  logic [31:0] srcAddr, dstAddr;

  assign hdrW = hdr[31:0];
  assign hdrH = hdr[63:32];

  assign hdrBad = (hdrW[31:16] != 16'd0) || (hdrH[31:16] != 16'd0) ||
                  (hdrW == 32'd0) || (hdrW > 32'(MAX_WIDTH)) ||
                  (hdrH == 32'd0) || (hdrH > 32'(MAX_HEIGHT));

  assign lastByte = (y == height - 11'd1) && (x == width - 11'd1) && (rgb == 2'd2);

  always_comb begin
    nextState = state;
    nx        = x;
    ny        = y;
    nRgb      = rgb;
    case (state)
      IDLE, DONE: if (start) nextState = HDR_RD;
      HDR_RD:     nextState = HDR_CAP;
      HDR_CAP:    nextState = (idx == HDR_LAST) ? CHECK : HDR_RD;
      CHECK:      nextState = hdrBad ? DONE : PIX_RD;
      PIX_RD:     nextState = PIX_WR;
      PIX_WR: begin
        nextState = lastByte ? DONE : PIX_RD;
        if (rgb == 2'd2) begin
          nRgb = 2'd0;
          if (x == width - 11'd1) begin
            nx = 11'd0;
            ny = y + 11'd1;
          end else begin
            nx = x + 11'd1;
          end
        end else begin
          nRgb = rgb + 2'd1;
        end
      end
      default:    nextState = IDLE;
    endcase
  end

  // In CHECK the geometry registers are not loaded yet, so the first
  // source address is formed straight from the captured header.
  always_comb begin
    geoW = width;
    geoH = height;
    geoS = stride;
    if (state == CHECK) begin
      geoW = hdrW[10:0];
      geoH = hdrH[10:0];
      geoS = padded_stride(hdrW[10:0]);
    end
  end

  bmp_addr_gen #(.HDR_BYTES(HDR_BYTES)) addrGen (
    .x       (nx),
    .y       (ny),
    .rgb     (nRgb),
    .width   (geoW),
    .height  (geoH),
    .stride  (geoS),
    .srcAddr (srcAddr),
    .dstAddr (dstAddr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 3'd0;
      hdr       <= 64'd0;
      x         <= 11'd0;
      y         <= 11'd0;
      rgb       <= 2'd0;
      stride    <= 13'd0;
      errReg    <= 1'b0;
      width     <= 11'd0;
      height    <= 11'd0;
      readAddr  <= 32'd0;
      writeAddr <= 32'd0;
    end else begin
      state <= nextState;
      x     <= nx;
      y     <= ny;
      rgb   <= nRgb;
      case (state)
        IDLE, DONE: if (start) begin
          idx      <= 3'd0;
          x        <= 11'd0;
          y        <= 11'd0;
          rgb      <= 2'd0;
          errReg   <= 1'b0;
          readAddr <= 32'(WIDTH_OFS);
        end
        HDR_CAP: begin
          hdr <= {readdata, hdr[63:8]};
          if (idx != HDR_LAST) begin
            idx      <= idx + 3'd1;
            readAddr <= 32'(WIDTH_OFS) + 32'(idx) + 32'd1;
          end
        end
        CHECK: begin
          width  <= hdrW[10:0];
          height <= hdrH[10:0];
          if (hdrBad) begin
            errReg <= 1'b1;
          end else begin
            stride   <= padded_stride(hdrW[10:0]);
            readAddr <= srcAddr;
          end
        end
        PIX_RD: writeAddr <= dstAddr;
        PIX_WR: if (!lastByte) readAddr <= srcAddr;
        default: ;
      endcase
    end
  end

  assign done   = (state == DONE);
  assign err    = errReg;
  assign wren   = (state == PIX_WR);
  assign wrdata = wren ? readdata : 8'd0;

endmodule
